// File: rtl/rbcp_initiator.sv
// rbcp_initiator: RBCP register-bus master driven by a local command/response handshake
//
// Runs one RBCP read or write at a time. The sequence is IDLE -> SETUP -> STROBE -> WAIT -> RESP.
// If no ACK arrives within TIMEOUT cycles of WAIT, the transaction is aborted and a
// saturating timeout counter is incremented.
//
// Ports:
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_cmd_valid / o_cmd_ready          command handshake
//   i_cmd_write, i_cmd_addr, i_cmd_wd  command: 1 = write, address, write data
//   o_rsp_valid / i_rsp_ready          response handshake
//   o_rsp_rd, o_rsp_timeout            read data (00 for write or timeout), abort flag
//   o_rbcp_act, o_rbcp_addr, o_rbcp_wd RBCP bus-active, address, write data
//   o_rbcp_we, o_rbcp_re               single-cycle write / read strobes
//   i_rbcp_ack, i_rbcp_rd              slave acknowledge and read data
//   o_busy                             high in every state except IDLE
//   o_timeout_count                    saturating count of timed-out transactions
module rbcp_initiator #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [31:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_wd,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [7:0]  o_rsp_rd,
    output logic        o_rsp_timeout,
    output logic        o_rbcp_act,
    output logic [31:0] o_rbcp_addr,
    output logic [7:0]  o_rbcp_wd,
    output logic        o_rbcp_we,
    output logic        o_rbcp_re,
    input  logic        i_rbcp_ack,
    input  logic [7:0]  i_rbcp_rd,
    output logic        o_busy,
    output logic [15:0] o_timeout_count
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, RESP} state_t;

    state_t      r_state;
    logic        r_write;
    logic [TO_W-1:0] r_cnt;
    logic        r_cmd_ready, r_rsp_valid, r_rsp_to, r_act, r_we, r_re, r_busy;
    logic [31:0] r_addr;
    logic [7:0]  r_wd, r_rsp_rd;
    logic [15:0] r_to_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_to    <= 1'b0;
            r_act       <= 1'b0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_busy      <= 1'b0;
            r_addr      <= '0;
            r_wd        <= '0;
            r_rsp_rd    <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;
            case (r_state)
                IDLE: if (i_cmd_valid) begin
                    r_addr      <= i_cmd_addr;
                    r_wd        <= i_cmd_wd;
                    r_write     <= i_cmd_write;
                    r_cmd_ready <= 1'b0;
                    r_act       <= 1'b1;
                    r_busy      <= 1'b1;
                    r_state     <= SETUP;
                end
                SETUP: begin
                    r_we    <= r_write;
                    r_re    <= !r_write;
                    r_state <= STROBE;
                end
                STROBE, WAIT: begin
                    // ACK takes priority over the timeout condition in the same cycle
                    if (i_rbcp_ack) begin
                        r_state     <= RESP;
                        r_act       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rd    <= r_write ? 8'h00 : i_rbcp_rd;
                        r_rsp_to    <= 1'b0;
                    end else if (r_state == STROBE) begin
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end else if (r_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_state     <= RESP;
                        r_act       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rd    <= 8'h00;
                        r_rsp_to    <= 1'b1;
                        r_to_cnt    <= &r_to_cnt ? r_to_cnt : r_to_cnt + 16'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: if (i_rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cmd_ready     = r_cmd_ready;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_rd        = r_rsp_rd;
    assign o_rsp_timeout   = r_rsp_to;
    assign o_rbcp_act      = r_act;
    assign o_rbcp_addr     = r_addr;
    assign o_rbcp_wd       = r_wd;
    assign o_rbcp_we       = r_we;
    assign o_rbcp_re       = r_re;
    assign o_busy          = r_busy;
    assign o_timeout_count = r_to_cnt;
endmodule

// File: tb/tb_rbcp_initiator.sv
// tb_rbcp_initiator: directed scoreboard bench for rbcp_initiator
module tb_rbcp_initiator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_wd = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [7:0]  rsp_rd;
    logic        act, we, re, ack = 1'b0, busy;
    logic [31:0] addr;
    logic [7:0]  wd, slv_rd = '0;
    logic [15:0] to_count;

    typedef struct {
        logic [7:0] rd;
        logic       to;
    } rsp_t;
    rsp_t q[$];

    int vectors = 0;
    int errors = 0;

    rbcp_initiator #(.TIMEOUT(16), .TO_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wd(cmd_wd),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rd(rsp_rd),
        .o_rsp_timeout(rsp_timeout),
        .o_rbcp_act(act), .o_rbcp_addr(addr), .o_rbcp_wd(wd), .o_rbcp_we(we), .o_rbcp_re(re),
        .i_rbcp_ack(ack), .i_rbcp_rd(slv_rd),
        .o_busy(busy), .o_timeout_count(to_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept happens at the next edge; returns in cycle k+1.
    task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input logic exp_to);
        rsp_t e;
        e.rd = exp_rd;
        e.to = exp_to;
        q.push_back(e);
        chk("cmd_ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wd    = d;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hDEAD_BEEF;
        cmd_wd    = 8'hEE;
    endtask

    task automatic resp(input string tag);
        rsp_t e;
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard: observed response, expected none", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_rd"}, rsp_rd, e.rd);
            chk({tag, "_to"}, rsp_timeout, e.to);
        end
        chk({tag, "_resp_ready"}, cmd_ready, 0);
        chk({tag, "_resp_act"}, act, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_idle_ready"}, cmd_ready, 1);
        chk({tag, "_idle_valid"}, rsp_valid, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int act_cycles, n, bad;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_act", act, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_to_count", to_count, 0);

        // 1: write, ACK two cycles after WE
        issue(1'b1, 32'h0000_0010, 8'hA5, 8'h00, 1'b0);
        chk("t1_k1_act", act, 1);
        chk("t1_k1_we", we, 0);
        chk("t1_k1_addr", addr, 32'h10);
        chk("t1_k1_wd", wd, 8'hA5);
        tick();
        chk("t1_k2_we", we, 1);
        chk("t1_k2_re", re, 0);
        tick();
        chk("t1_k3_we", we, 0);
        tick();
        ack = 1'b1;
        chk("t1_ack_addr", addr, 32'h10);
        chk("t1_ack_wd", wd, 8'hA5);
        tick();
        ack = 1'b0;
        chk("t1_lat_valid", rsp_valid, 1);
        resp("t1");
        chk("t1_hold_addr", addr, 32'h10);

        // 2: read with ACK in the STROBE cycle
        issue(1'b0, 32'h0000_0020, 8'h00, 8'h3C, 1'b0);
        tick();
        chk("t2_k2_re", re, 1);
        chk("t2_k2_we", we, 0);
        ack = 1'b1;
        slv_rd = 8'h3C;
        tick();
        ack = 1'b0;
        slv_rd = 8'h00;
        chk("t2_k3_valid", rsp_valid, 1);
        chk("t2_k3_act", act, 0);
        resp("t2");

        // 3: read, no ACK -> timeout
        issue(1'b0, 32'h0000_0030, 8'h00, 8'h00, 1'b1);
        act_cycles = 0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            if (act) act_cycles++;
            tick();
            n++;
        end
        chk("t3_act_cycles", act_cycles, 18);
        chk("t3_latency", n, 18);
        chk("t3_to_count", to_count, 1);
        resp("t3");

        // 4: ACK on the last WAIT cycle wins over the timeout
        issue(1'b0, 32'h0000_0040, 8'h00, 8'h5A, 1'b0);
        repeat (17) tick();
        chk("t4_k18_act", act, 1);
        chk("t4_k18_valid", rsp_valid, 0);
        ack = 1'b1;
        slv_rd = 8'h5A;
        tick();
        ack = 1'b0;
        slv_rd = 8'h00;
        chk("t4_valid", rsp_valid, 1);
        chk("t4_to_count", to_count, 1);
        resp("t4");

        // 5: RSP_READY low for 10 cycles with a stray ACK in RESP
        issue(1'b0, 32'h0000_0050, 8'h00, 8'h77, 1'b0);
        tick();
        ack = 1'b1;
        slv_rd = 8'h77;
        tick();
        ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            ack    = (i == 3);
            slv_rd = (i == 3) ? 8'hFF : 8'h00;
            if (!rsp_valid || rsp_rd !== 8'h77 || rsp_timeout || cmd_ready || act || we || re) bad++;
            tick();
        end
        ack = 1'b0;
        slv_rd = 8'h00;
        chk("t5_hold_bad_cycles", bad, 0);
        resp("t5");

        // 6: reset in WAIT aborts with no response, then a write completes
        issue(1'b0, 32'h0000_0060, 8'h00, 8'h00, 1'b1);
        repeat (4) tick();
        chk("t6_pre_act", act, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(q.pop_back());
        chk("t6_act", act, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_to_count", to_count, 0);
        issue(1'b1, 32'h0000_0070, 8'h11, 8'h00, 1'b0);
        chk("t6_w_addr", addr, 32'h70);
        tick();
        chk("t6_w_we", we, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        resp("t6");
        chk("t6_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
